// File: rtl/dbi_pkg.sv
// Shared definitions for the DBI-AC burst sequencer and its decision block.
// Holds FSM encodings, park default, tie threshold and stats width.
package dbi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } dbi_state_e;

  localparam logic [7:0]  DBI_PARK_DEFAULT = 8'hFF;
  localparam int unsigned DBI_HALF         = 4;
  localparam int unsigned DBI_STAT_W       = 16;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/dbi_ac_decide.sv
// Combinational DBI-AC inversion decision for one byte lane against a reference bus.
// Shared with the read-side decoder checker.
module dbi_ac_decide
  import dbi_pkg::*;
(
  input  logic [7:0] in_data,
  input  logic [7:0] ref_data,
  input  logic       ref_dbi,
  input  logic       en,
  output logic       inv
);

  logic [3:0] toggles;

  always_comb begin
    toggles = popcount8(in_data ^ ref_data);
    inv     = 1'b0;
    if (en) begin
      if (toggles > 4'(DBI_HALF)) begin
        inv = 1'b1;
      end else if (toggles == 4'(DBI_HALF)) begin
        // On a tie keep the DBI wire where it is so it adds no toggle.
        inv = ref_dbi;
      end
    end
  end

endmodule

// File: rtl/dbi_ac_burst_ctrl.sv
// Burst sequencer for the byte-lane DBI-AC encoder: per-beat inversion, burst framing, bus parking.
// Optional beat/inversion statistics counters are built when DBI_STATS_EN is defined.
module dbi_ac_burst_ctrl
  import dbi_pkg::*;
#(
  parameter int unsigned BURST_LEN = 8,
  parameter logic [7:0]  PARK_DATA = DBI_PARK_DEFAULT,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbi_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_dbi,
  output logic        burst_first,
  output logic        burst_last,
  output logic        busy,
  output logic [15:0] stat_inv,
  output logic [15:0] stat_beats
);

  localparam logic [CNT_W:0] BL_CMP   = (CNT_W+1)'(BURST_LEN);
  localparam logic           ONE_BEAT = (BURST_LEN == 1);

  dbi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             en_q, en_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_dbi_q, out_dbi_d;
  logic             first_q, first_d;
  logic             last_q, last_d;

  logic             accept;
  logic [7:0]       ref_data;
  logic             ref_dbi;
  logic             dec_en;
  logic             inv;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Outside a burst the next beat is a first beat: use the live enable, which gets latched.
  always_comb begin
    ref_data = (state_q == IDLE) ? PARK_DATA : out_data_q;
    ref_dbi  = (state_q == IDLE) ? 1'b0 : out_dbi_q;
    dec_en   = (state_q == BURST) ? en_q : dbi_en;
    cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  end

  dbi_ac_decide u_decide (
    .in_data  (in_data),
    .ref_data (ref_data),
    .ref_dbi  (ref_dbi),
    .en       (dec_en),
    .inv      (inv)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_d        = en_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_dbi_d   = out_dbi_q;
    first_d     = first_q;
    last_d      = last_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = inv ? ~in_data : in_data;
      out_dbi_d   = inv;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      first_d     = 1'b0;
      last_d      = 1'b0;
    end

    case (state_q)
      IDLE, GAP: begin
        if (accept) begin
          cnt_d   = CNT_W'(1);
          en_d    = dbi_en;
          first_d = 1'b1;
          last_d  = ONE_BEAT;
          state_d = ONE_BEAT ? GAP : BURST;
        end else if (state_q == GAP && !out_valid_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      BURST: begin
        if (accept) begin
          cnt_d   = cnt_inc[CNT_W-1:0];
          first_d = 1'b0;
          last_d  = (cnt_inc == BL_CMP);
          state_d = (cnt_inc == BL_CMP) ? GAP : BURST;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= PARK_DATA;
      out_dbi_q   <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dbi_q   <= out_dbi_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_dbi     = out_dbi_q;
  assign burst_first = first_q;
  assign burst_last  = last_q;
  assign busy        = (state_q != IDLE) || out_valid_q;

`ifdef DBI_STATS_EN
  logic [DBI_STAT_W-1:0] stat_inv_q, stat_inv_d;
  logic [DBI_STAT_W-1:0] stat_beats_q, stat_beats_d;

  always_comb begin
    stat_inv_d   = stat_inv_q;
    stat_beats_d = stat_beats_q;
    if (out_valid_q && out_ready) begin
      if (stat_beats_q != '1) begin
        stat_beats_d = stat_beats_q + 1'b1;
      end
      if (out_dbi_q && stat_inv_q != '1) begin
        stat_inv_d = stat_inv_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_inv_q   <= '0;
      stat_beats_q <= '0;
    end else begin
      stat_inv_q   <= stat_inv_d;
      stat_beats_q <= stat_beats_d;
    end
  end

  assign stat_inv   = stat_inv_q;
  assign stat_beats = stat_beats_q;
`else
  assign stat_inv   = '0;
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_dbi_ac_burst_ctrl.sv
// Directed table-driven bench for dbi_ac_burst_ctrl (BURST_LEN=8, PARK_DATA=8'hFF).
module tb_dbi_ac_burst_ctrl;

  logic        clk;
  logic        rst_n;
  logic        dbi_en;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_dbi;
  logic        burst_first;
  logic        burst_last;
  logic        busy;
  logic [15:0] stat_inv;
  logic [15:0] stat_beats;

  int checks;
  int errors;

  dbi_ac_burst_ctrl #(
    .BURST_LEN (8),
    .PARK_DATA (8'hFF),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dbi_en      (dbi_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_dbi     (out_dbi),
    .burst_first (burst_first),
    .burst_last  (burst_last),
    .busy        (busy),
    .stat_inv    (stat_inv),
    .stat_beats  (stat_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       en;
    logic       ordy;
    logic       irdy;
    logic       ov;
    logic [7:0] od;
    logic       odbi;
    logic       f;
    logic       l;
    logic       bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic en,
                              input logic ordy, input logic irdy, input logic ov,
                              input logic [7:0] od, input logic odbi, input logic f,
                              input logic l, input logic bsy);
    vec_t v;
    v.iv = iv; v.d = d; v.en = en; v.ordy = ordy; v.irdy = irdy; v.ov = ov;
    v.od = od; v.odbi = odbi; v.f = f; v.l = l; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " out_valid"},   {15'd0, out_valid},   {15'd0, v.ov});
    chk({tag, " out_data"},    {8'd0, out_data},     {8'd0, v.od});
    chk({tag, " out_dbi"},     {15'd0, out_dbi},     {15'd0, v.odbi});
    chk({tag, " burst_first"}, {15'd0, burst_first}, {15'd0, v.f});
    chk({tag, " burst_last"},  {15'd0, burst_last},  {15'd0, v.l});
    chk({tag, " busy"},        {15'd0, busy},        {15'd0, v.bsy});
  endtask

  // Drive on the falling edge, check in_ready before the rising edge and outputs just after it.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    in_valid  = v.iv;
    in_data   = v.d;
    dbi_en    = v.en;
    out_ready = v.ordy;
    #1;
    chk({tag, " in_ready"}, {15'd0, in_ready}, {15'd0, v.irdy});
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    dbi_en    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // Burst 1: tie and threshold cases against park and previous beats.
    tbl.push_back(mk(1, 8'h00, 1, 1, 1, 1, 8'hFF, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'hF0, 1, 1, 1, 1, 8'h0F, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'h0F, 1, 1, 1, 1, 8'h0F, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h00, 1, 1, 1, 1, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h0F, 1, 1, 1, 1, 8'h0F, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h0E, 1, 1, 1, 1, 8'h0E, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'hF1, 1, 1, 1, 1, 8'h0E, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'h12, 1, 1, 1, 1, 8'h12, 0, 0, 1, 1));
    // Beat 9 back-to-back: decided against beat 8, not park.
    tbl.push_back(mk(1, 8'hED, 1, 1, 1, 1, 8'h12, 1, 1, 0, 1));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 8'h12, 1, 1, 1, 1, 8'h12, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h12, 1, 1, 1, 1, 8'h12, 0, 0, 1, 1));
    // Two idle cycles: GAP then IDLE.
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 8'h12, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 8'h12, 0, 0, 0, 0));
    // Re-parked: 00 against FF inverts. dbi_en dropped mid-burst is ignored.
    tbl.push_back(mk(1, 8'h00, 1, 1, 1, 1, 8'hFF, 1, 1, 0, 1));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 8'h00, 0, 1, 1, 1, 8'hFF, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'h00, 0, 1, 1, 1, 8'hFF, 1, 0, 1, 1));
    // Burst with dbi_en=0 at first beat, raised at beat 4: never inverts.
    tbl.push_back(mk(1, 8'h00, 0, 1, 1, 1, 8'h00, 0, 1, 0, 1));
    tbl.push_back(mk(1, 8'hFF, 0, 1, 1, 1, 8'hFF, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h00, 0, 1, 1, 1, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'hFF, 1, 1, 1, 1, 8'hFF, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h00, 1, 1, 1, 1, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'hFF, 1, 1, 1, 1, 8'hFF, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h00, 1, 1, 1, 1, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'hFF, 1, 1, 1, 1, 8'hFF, 0, 0, 1, 1));
    // Backpressure: three stalled cycles hold the output and deassert in_ready.
    tbl.push_back(mk(1, 8'hAA, 0, 1, 1, 1, 8'hAA, 0, 1, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'h55, 0, 0, 0, 1, 8'hAA, 0, 1, 0, 1));
    tbl.push_back(mk(1, 8'h55, 0, 1, 1, 1, 8'h55, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h33, 0, 1, 1, 1, 8'h33, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'hCC, 0, 1, 1, 1, 8'hCC, 0, 0, 0, 1));

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", mk(0, 8'h00, 0, 1, 1, 0, 8'hFF, 0, 0, 0, 0));
    chk("reset stat_inv", stat_inv, 16'h0000);
    chk("reset stat_beats", stat_beats, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset at beat 5 of the stalled burst: beat dropped, outputs reset at once.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h77;
    dbi_en    = 1'b1;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    check_outs("midrst", mk(0, 8'h00, 0, 1, 1, 0, 8'hFF, 0, 0, 0, 0));
    chk("midrst stat_beats", stat_beats, 16'h0000);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outs("midrst_hold", mk(0, 8'h00, 0, 1, 1, 0, 8'hFF, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    step(mk(1, 8'h00, 1, 1, 1, 1, 8'hFF, 1, 1, 0, 1), "postrst_first");
    step(mk(0, 8'h00, 1, 1, 1, 0, 8'hFF, 1, 0, 0, 1), "postrst_drain");
`ifdef DBI_STATS_EN
    chk("stat_beats", stat_beats, 16'h0001);
    chk("stat_inv", stat_inv, 16'h0001);
`else
    chk("stat_beats", stat_beats, 16'h0000);
    chk("stat_inv", stat_inv, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
